// File: rtl/serial_subtract_ctrl.sv
// Bit-serial subtractor: one full_subtractor cell is reused for WIDTH cycles,
// LSB first, computing A - B - Bin with a registered borrow chaining the bits.

// Single-bit full subtractor cell: d = a - b - bin, bout = borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_subtract_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // One-hot so ready and done each come straight off a single flop.
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        RUN  = 3'b010,
        DONE = 3'b100
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, d_sh, d_nx;
    logic [CW-1:0]    cnt;
    logic             borrow_q;
    logic             cell_d, cell_b;
    logic             last;

    full_subtractor u_fs (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_b)
    );

    // Next value of the result shifter: new bit enters at the MSB.
    generate
        if (WIDTH == 1) begin : g_w1
            assign d_nx = cell_d;
        end else begin : g_wn
            assign d_nx = {cell_d, d_sh[WIDTH-1:1]};
        end
    endgenerate

    assign last  = (cnt == LAST);
    assign ready = state[0];
    assign busy  = state[1] | state[2];
    assign done  = state[2];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state: IDLE -> RUN on start, RUN -> DONE after WIDTH bits, DONE -> IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, shift one bit per RUN cycle,
    // publish result only on the final RUN edge so outputs hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh       <= '0;
            b_sh       <= '0;
            d_sh       <= '0;
            borrow_q   <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_sh     <= a;
                    b_sh     <= b;
                    borrow_q <= bin;
                    cnt      <= '0;
                end
                RUN: begin
                    d_sh     <= d_nx;
                    a_sh     <= a_sh >> 1;
                    b_sh     <= b_sh >> 1;
                    borrow_q <= cell_b;
                    cnt      <= cnt + CW'(1);
                    if (last) begin
                        diff       <= d_nx;
                        borrow_out <= cell_b;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtract_ctrl.sv
// Directed bench for serial_subtract_ctrl: an 8-bit instance for the main
// scenarios and a 1-bit instance for the full-subtractor truth table.
module tb_serial_subtract_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, bin;
    logic [7:0] a, b;
    logic       ready, busy, done, borrow_out;
    logic [7:0] diff;
    logic       start1, a1, b1, bin1;
    logic       ready1, busy1, done1, diff1, borrow_out1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_subtract_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .ready(ready), .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
    );

    serial_subtract_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .ready(ready1), .busy(busy1), .done(done1), .diff(diff1), .borrow_out(borrow_out1)
    );

    // Stimulus only: one 8-bit op accepted at the next edge; returns after
    // the DONE->IDLE edge with the number of done cycles observed.
    task automatic do_op8(input logic [7:0] aa, input logic [7:0] bb, input logic bi,
                          output int ndone);
        ndone = 0;
        @(negedge clk); a = aa; b = bb; bin = bi; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (9) begin
            @(negedge clk);
            if (done) ndone++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 0; a = 0; b = 0; bin = 0;
        start1 = 0; a1 = 0; b1 = 0; bin1 = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (diff !== 8'h00) begin bad++; $display("FAIL reset_diff got=%h want=00", diff); end
        total++; if (borrow_out !== 1'b0) begin bad++; $display("FAIL reset_borrow got=%b want=0", borrow_out); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({ready, busy, done, borrow_out, diff} !== {4'b1000, 8'h00}) begin
                bad++;
                $display("FAIL idle_hold cyc=%0d got r=%b b=%b d=%b bo=%b diff=%h want r=1 b=0 d=0 bo=0 diff=00",
                         i, ready, busy, done, borrow_out, diff);
            end
        end
    endtask

    task automatic test_basic;
        @(negedge clk); a = 8'd100; b = 8'd37; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        // operands change right after acceptance; result must not follow
        start = 1'b0; a = 8'hFF; b = 8'hFF; bin = 1'b1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_e0 got=%b want=1", busy); end
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            total++;
            if (done !== (k == 8)) begin bad++; $display("FAIL basic_done edge=%0d got=%b want=%b", k, done, (k == 8)); end
            total++;
            if (busy !== (k <= 8)) begin bad++; $display("FAIL basic_busy edge=%0d got=%b want=%b", k, busy, (k <= 8)); end
            if (k == 4) begin
                total++;
                if (diff !== 8'h00) begin bad++; $display("FAIL basic_hold_midrun got=%h want=00", diff); end
            end
        end
        total++; if (diff !== 8'h3F) begin bad++; $display("FAIL basic_diff got=%h want=3f", diff); end
        total++; if (borrow_out !== 1'b0) begin bad++; $display("FAIL basic_borrow got=%b want=0", borrow_out); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b want=1", ready); end
        repeat (3) @(negedge clk);
        total++; if (diff !== 8'h3F) begin bad++; $display("FAIL basic_hold got=%h want=3f", diff); end
    endtask

    task automatic test_negative;
        int nd;
        do_op8(8'd37, 8'd100, 1'b0, nd);
        total++; if (diff !== 8'hC1) begin bad++; $display("FAIL neg_diff got=%h want=c1", diff); end
        total++; if (borrow_out !== 1'b1) begin bad++; $display("FAIL neg_borrow got=%b want=1", borrow_out); end
        total++; if (nd !== 1) begin bad++; $display("FAIL neg_ndone got=%0d want=1", nd); end
        do_op8(8'h00, 8'h00, 1'b1, nd);
        total++; if (diff !== 8'hFF) begin bad++; $display("FAIL zero_bin_diff got=%h want=ff", diff); end
        total++; if (borrow_out !== 1'b1) begin bad++; $display("FAIL zero_bin_borrow got=%b want=1", borrow_out); end
    endtask

    task automatic test_ignored_and_back_to_back;
        int nd;
        nd = 0;
        @(negedge clk); a = 8'h50; b = 8'h10; bin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (done) nd++;
            if (k == 2) begin start = 1'b1; a = 8'hFF; b = 8'h00; end
            if (k == 3) start = 1'b0;
            if (k == 8) begin start = 1'b1; a = 8'hFF; b = 8'h00; end
            if (k == 9) begin start = 1'b1; a = 8'h20; b = 8'h30; end
        end
        total++; if (nd !== 1) begin bad++; $display("FAIL ign_ndone got=%0d want=1", nd); end
        total++; if (diff !== 8'h40) begin bad++; $display("FAIL ign_diff got=%h want=40", diff); end
        total++; if (borrow_out !== 1'b0) begin bad++; $display("FAIL ign_borrow got=%b want=0", borrow_out); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL ign_ready got=%b want=1", ready); end
        @(negedge clk); start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b want=1", busy); end
        nd = 0;
        for (int k = 11; k <= 19; k++) begin
            @(negedge clk);
            if (done) nd++;
            if (k == 18) begin
                total++;
                if (done !== 1'b1) begin bad++; $display("FAIL b2b_done_edge18 got=%b want=1", done); end
            end
        end
        total++; if (nd !== 1) begin bad++; $display("FAIL b2b_ndone got=%0d want=1", nd); end
        total++; if (diff !== 8'hF0) begin bad++; $display("FAIL b2b_diff got=%h want=f0", diff); end
        total++; if (borrow_out !== 1'b1) begin bad++; $display("FAIL b2b_borrow got=%b want=1", borrow_out); end
    endtask

    task automatic test_midop_reset;
        int nd;
        int sawdone;
        @(negedge clk); a = 8'h12; b = 8'h01; bin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(posedge clk);
        #5 rst_n = 1'b0;
        #1;
        total++; if (diff !== 8'h00) begin bad++; $display("FAIL mid_rst_diff got=%h want=00", diff); end
        total++; if (borrow_out !== 1'b0) begin bad++; $display("FAIL mid_rst_borrow got=%b want=0", borrow_out); end
        total++; if ({ready, busy, done} !== 3'b100) begin bad++; $display("FAIL mid_rst_state got=%b want=100", {ready, busy, done}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sawdone = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) sawdone++;
        end
        total++; if (sawdone !== 0) begin bad++; $display("FAIL mid_rst_nodone got=%0d want=0", sawdone); end
        do_op8(8'hAA, 8'h55, 1'b0, nd);
        total++; if (diff !== 8'h55) begin bad++; $display("FAIL post_rst_diff got=%h want=55", diff); end
        total++; if (borrow_out !== 1'b0) begin bad++; $display("FAIL post_rst_borrow got=%b want=0", borrow_out); end
        total++; if (nd !== 1) begin bad++; $display("FAIL post_rst_ndone got=%0d want=1", nd); end
    endtask

    task automatic test_width1;
        logic [2:0] v;
        int         r;
        logic       exp_d, exp_bo;
        for (int i = 0; i < 8; i++) begin
            v = i[2:0];
            r = int'(v[2]) - int'(v[1]) - int'(v[0]);
            exp_d  = (r % 2 != 0);
            exp_bo = (r < 0);
            @(negedge clk); a1 = v[2]; b1 = v[1]; bin1 = v[0]; start1 = 1'b1;
            @(negedge clk); start1 = 1'b0;
            total++; if ({busy1, done1} !== 2'b10) begin bad++; $display("FAIL w1_e0 v=%b got busy/done=%b want=10", v, {busy1, done1}); end
            @(negedge clk);
            total++; if (done1 !== 1'b1) begin bad++; $display("FAIL w1_done v=%b got=%b want=1", v, done1); end
            total++; if (diff1 !== exp_d) begin bad++; $display("FAIL w1_diff v=%b got=%b want=%b", v, diff1, exp_d); end
            total++; if (borrow_out1 !== exp_bo) begin bad++; $display("FAIL w1_borrow v=%b got=%b want=%b", v, borrow_out1, exp_bo); end
            @(negedge clk);
            total++; if ({ready1, done1} !== 2'b10) begin bad++; $display("FAIL w1_e2 v=%b got ready/done=%b want=10", v, {ready1, done1}); end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_negative;
        test_ignored_and_back_to_back;
        test_midop_reset;
        test_width1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_subtract_ctrl.md
Name: serial_subtract_ctrl

Overview:
Bit-serial multi-bit subtractor controller. It time-shares one full_subtractor cell across WIDTH cycles to compute A - B - Bin, LSB first. A registered borrow chains the bits. Used where area matters more than latency; it sits between a requesting master (start/done handshake) and the single subtractor cell it sequences.

Parameters:
WIDTH, 8, operand/result width in bits; legal range WIDTH >= 1.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only when ready=1.
a  input  WIDTH  minuend; captured on accepted start.
b  input  WIDTH  subtrahend; captured on accepted start.
bin  input  1  initial borrow-in; captured on accepted start.
ready  output  1  high in IDLE only.
busy  output  1  high in RUN and DONE.
done  output  1  one-cycle completion pulse.
diff  output  WIDTH  result (A - B - Bin) mod 2^WIDTH; held between operations.
borrow_out  output  1  final borrow; 1 when A < B + Bin (unsigned); held.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: asynchronous on rst_n low. State goes to IDLE; ready=1 and busy=0. done=0, diff=0, borrow_out=0. Internal shift registers, borrow register and bit counter are cleared. Reset mid-RUN aborts the operation with no done and no result update.
- Datapath: exactly one full_subtractor instance. Its inputs are a_sh[0], b_sh[0] and borrow_q. Its Difference output enters d_sh at the MSB. Its Borrow output loads borrow_q.
- FSM states are IDLE, RUN and DONE.
- IDLE: if start=1 at a rising edge, capture a into a_sh, b into b_sh and bin into borrow_q. Clear cnt to 0 and go to RUN. Otherwise stay in IDLE.
- RUN, at each edge:
  - d_sh <= {cell Difference, d_sh[WIDTH-1:1]}.
  - a_sh and b_sh shift right by 1.
  - borrow_q <= cell Borrow.
  - cnt <= cnt + 1.
- RUN completion: at the edge where cnt == WIDTH-1 (the WIDTH-th RUN edge), load diff with the final shifted value. Load borrow_out with the cell Borrow. Go to DONE.
- DONE: done=1 for exactly this one cycle, then unconditionally return to IDLE.
- Latency: start is sampled at edge 0. RUN occupies edges 1..WIDTH. done is high between edges WIDTH and WIDTH+1. The next start is accepted no earlier than edge WIDTH+2 after the previous start.
- Ignored start: start while busy=1 (RUN or DONE) has no effect. Operands are not re-captured. The request is not queued.
- Operand stability: a, b and bin are sampled only at the accepting edge. Later changes during RUN do not affect the result.
- Output hold: diff and borrow_out change only at the completing RUN edge or on reset. They are stable in IDLE and across start acceptance.
- Counter: cnt is sized clog2(WIDTH)+1 bits. It never wraps during operation.
- WIDTH=1: one RUN cycle; done high between edges 1 and 2.
- ready and busy are decoded from state registers (glitch-free). Exactly one of ready/busy is high at all times after reset.

Test Plan:
- Reset then idle, WIDTH=8: hold rst_n=0 for 3 cycles, then release. Required: ready=1, busy=0, done=0, diff=0x00, borrow_out=0. No change for 10 idle cycles.
- Basic subtract: a=100, b=37, bin=0, one-cycle start at edge 0. Required: busy over edges 1..9; done high only between edges 8 and 9; diff=0x3F, borrow_out=0. Values hold afterward.
- Negative result: a=37, b=100, bin=0. Required: diff=0xC1, borrow_out=1. With a=0, b=0, bin=1: diff=0xFF, borrow_out=1.
- Ignored start: start at edge 0 (a=0x50, b=0x10); drive start=1 with a=0xFF, b=0x00 on edges 3 and 9. Required: single done, diff=0x40, borrow_out=0, no second operation. Back-to-back: start at edge 10 is accepted.
- Mid-op reset: assert rst_n=0 asynchronously at edge 4 + half a cycle of an operation. Required: outputs clear immediately; no done pulse; the next full operation computes correctly (0xAA - 0x55 = 0x55, borrow 0).
- WIDTH=1 instance: all 8 combinations of a, b, bin. Required: diff/borrow_out match the full-subtractor truth table; done between edges 1 and 2.
